// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    // Control states of the serial subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: two chained half-difference stages whose
// borrows are OR-ed together.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First half stage (a - b), then second half stage (d1 - bin)
    always_comb begin
        d1   = a ^ b;
        b1   = ~a & b;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: accepts a/b, computes a - b LSB-first one
// bit per clock through a single full_sub_bit cell, then holds the result
// until the consumer takes it.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_e       state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] diff_sr_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;

    logic             bit_d;
    logic             borrow_d;

    // The only arithmetic in the datapath: the current LSBs plus the borrow
    full_sub_bit u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (borrow_d)
    );

    // FSM and datapath registers; handshake decodes come from state only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    // Operands drain LSB-first; result fills from the MSB so
                    // that after WIDTH shifts it sits fully aligned.
                    a_sr_q    <= a_sr_q >> 1;
                    b_sr_q    <= b_sr_q >> 1;
                    diff_sr_q <= {bit_d, diff_sr_q[WIDTH-1:1]};
                    borrow_q  <= borrow_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result and borrow are untouched here, so they stay
                    // stable under backpressure.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_sr_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow_out;

    int total = 0;
    int bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Offer one operand pair, return cycles from accept edge to out_valid
    task automatic send(input logic [7:0] va, input logic [7:0] vb, output int lat);
        @(negedge clk);
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        logic [7:0] hd;
        logic       hb;
        logic       seen;
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int         sent;
        int         recv;
        logic       held;
        logic       fin;
        logic [7:0] ea;
        logic [7:0] eb;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h3C, 8'h5A, 8'hE2, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h00, 8'h80, 1'b0};

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].va, vecs[i].vb, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_borrow", i), 32'(borrow_out), 32'(vecs[i].eb));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid_one_cycle", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_back_to_idle", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held, foreign operands ignored
        out_ready = 1'b0;
        send(8'h5A, 8'h3C, lat);
        chk("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'h11 + 8'(i);
            b = 8'h77;
            in_valid = 1'b1;
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_diff", 32'(diff), 32'h1E);
            chk("bp_borrow", 32'(borrow_out), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        hd = diff;
        hb = borrow_out;
        chk("bp_diff_final", 32'(hd), 32'h1E);
        chk("bp_borrow_final", 32'(hb), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk("bp_ignored_not_captured", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_diff", 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrun_no_result", 32'(seen), 32'd0);
        send(8'h10, 8'h01, lat);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_diff", 32'(diff), 32'h0F);
        chk("post_rst_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random handshakes and an in-order scoreboard
        sent = 0;
        recv = 0;
        held = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 40000 && recv < 1000; cyc++) begin
            @(negedge clk);
            if (!held) begin
                if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fin = in_valid && in_ready;
            if (fin) begin
                qa.push_back(a);
                qb.push_back(b);
                sent++;
            end
            held = in_valid && !fin;
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    chk("rand_spurious_result", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    chk("rand_diff", 32'(diff), 32'(8'(ea - eb)));
                    chk("rand_borrow", 32'(borrow_out), 32'(ea < eb));
                end
                recv++;
            end
        end
        in_valid = 1'b0;
        chk("rand_received", 32'(recv), 32'd1000);
        chk("rand_sent", 32'(sent), 32'd1000);
        chk("rand_queue_empty", 32'(qa.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor. It accepts an operand pair through a valid/ready handshake and computes a − b LSB-first, one bit per clock, using a single one-bit borrow-propagating cell and a borrow flip-flop. The result and final borrow are presented through a second valid/ready handshake. It extends the one-bit difference/borrow cell of the combinational library into a multi-bit sequential datapath stage.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/borrow_out valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load a_sr←a, b_sr←b, borrow←0, cnt←0; go to RUN.
- RUN, every cycle:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - a_sr and b_sr shift right by 1.
  - diff_sr shifts right with d inserted at the MSB.
  - borrow←borrow_next; cnt←cnt+1.
  - When cnt == WIDTH−1, go to DONE on the same edge.
- DONE:
  - out_valid=1; diff=diff_sr; borrow_out=borrow.
  - On out_ready: go to IDLE.
  - While out_ready=0, diff and borrow_out are held stable.
- in_valid outside IDLE is ignored; operands are not captured.
- Reset (asynchronous, any state):
  - State returns to IDLE; a_sr, b_sr, diff_sr, borrow, cnt are cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, diff=0, borrow_out=0.
  - A computation in progress is discarded; no out_valid follows.
- Arithmetic:
  - Pure unsigned modular subtraction; no saturation.
  - Two's-complement interpretation of diff is left to the consumer.
  - cnt is $clog2(WIDTH) bits wide and never wraps within one operation.

## Timing
- Accept edge = edge 0. RUN occupies edges 1..WIDTH. out_valid rises after edge WIDTH.
- Latency from accept to out_valid = WIDTH cycles.
- Result transfers on the first edge with out_valid & out_ready; in_ready rises the cycle after that edge.
- Minimum initiation interval = WIDTH+2 cycles. There is no overlap of a new accept with a DONE exit.
- diff/borrow_out are registered; there are no combinational paths from inputs to outputs.
- in_ready and out_valid decode from the state register only.
- diff is meaningful only while out_valid=1. Its value outside DONE is don't-care apart from the reset value of 0.

## Structure
- Shared package serial_sub_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant SERIAL_SUB_DEFAULT_WIDTH = 8.
- Sub-module full_sub_bit: combinational one-bit cell (a, b, bin → d, bout), built as two chained half-difference stages with OR-ed borrows. Instantiated once in the RUN datapath.
- Top level holds the FSM, the shift registers, the borrow flip-flop and cnt.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, out_ready=1 → diff=0x1E, borrow_out=0; out_valid exactly 8 cycles after accept, high for 1 cycle.
- a=0x3C, b=0x5A → diff=0xE2, borrow_out=1. a=0x00, b=0x01 → diff=0xFF, borrow_out=1 (full borrow ripple).
- a=0xFF, b=0xFF → diff=0x00, borrow_out=0. a=0x80, b=0x00 → diff=0x80, borrow_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, diff and borrow_out stable. Pulse in_valid with different operands during that time → ignored; in_ready=0 throughout. Release out_ready → IDLE next cycle.
- Deassert rst_n mid-RUN (after 3 bits) → in_ready=1, out_valid=0, diff=0 immediately, without waiting for clk. A fresh 0x10−0x01 after reset → diff=0x0F, borrow_out=0.
- Random 1000 back-to-back transactions with random in_valid/out_ready → diff == (a−b)&0xFF and borrow_out == (a<b) for every transfer, in order, none dropped or duplicated.
